// File: rtl/u_line_buffer_2row.sv
// ---------------------------------------------------------------------------
// u_line_buffer_2row
// Row-pair line buffer for the 2x2 window stage. It takes a raster-order 8-bit
// pixel stream and keeps one full image row in a line RAM. Each accepted pixel
// comes out one cycle later, paired with the pixel in the same column of the
// previous row.
//
// Ports
//   clk           : system clock, rising edge
//   rst           : synchronous reset, active-low
//   in_valid      : in_data holds a valid pixel this cycle
//   in_sof        : start of frame, qualified by in_valid; marks pixel (0,0)
//   in_data       : pixel value
//   out_ce        : output pair valid, a 1-cycle pulse per accepted pixel
//   data_line_0   : current-row pixel
//   data_line_1   : previous-row pixel in the same column; 0 on row 0
//   out_first_row : output pair belongs to row 0
//   out_eol       : output pair is the last column of its row
//   out_eof       : output pair is the last pixel of the frame
// ---------------------------------------------------------------------------
module u_line_buffer_2row #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COL_W      = 10,
  parameter int ROW_W      = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_sof,
  input  logic [7:0] in_data,
  output logic       out_ce,
  output logic [7:0] data_line_0,
  output logic [7:0] data_line_1,
  output logic       out_first_row,
  output logic       out_eol,
  output logic       out_eof
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};
  localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};
  localparam logic [COL_W-1:0] COL_ONE  = {{(COL_W-1){1'b0}}, 1'b1};
  localparam logic [ROW_W-1:0] ROW_ONE  = {{(ROW_W-1){1'b0}}, 1'b1};

  logic [COL_W-1:0] col_r;
  logic [ROW_W-1:0] row_r;
  logic [COL_W-1:0] eff_col_s;
  logic [ROW_W-1:0] eff_row_s;
  logic [COL_W-1:0] nxt_col_s;
  logic [ROW_W-1:0] nxt_row_s;
  logic             last_col_s;
  logic             last_row_s;
  logic             first_row_s;

  // Line RAM: one row of pixels. It is never cleared; row 0 masks stale data.
  logic [7:0] line_mem_r [0:IMG_WIDTH-1];

  // Position of the pixel being presented; in_sof forces (0,0) immediately.
  always_comb begin
    eff_col_s = col_r;
    eff_row_s = row_r;
    if (in_sof) begin
      eff_col_s = COL_ZERO;
      eff_row_s = ROW_ZERO;
    end else begin
      eff_col_s = col_r;
      eff_row_s = row_r;
    end
  end

  // Row/frame boundary flags for the effective position.
  always_comb begin
    last_col_s  = (eff_col_s == LAST_COL);
    last_row_s  = (eff_row_s == LAST_ROW);
    first_row_s = (eff_row_s == ROW_ZERO);
  end

  // Raster advance: step the column, and at the row end step the row, wrapping at the frame end.
  always_comb begin
    nxt_col_s = col_r;
    nxt_row_s = row_r;
    if (in_valid) begin
      if (!last_col_s) begin
        nxt_col_s = eff_col_s + COL_ONE;
        nxt_row_s = eff_row_s;
      end else begin
        nxt_col_s = COL_ZERO;
        if (!last_row_s) begin
          nxt_row_s = eff_row_s + ROW_ONE;
        end else begin
          nxt_row_s = ROW_ZERO;
        end
      end
    end else begin
      nxt_col_s = col_r;
      nxt_row_s = row_r;
    end
  end

  // Column/row counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      col_r <= COL_ZERO;
      row_r <= ROW_ZERO;
    end else begin
      col_r <= nxt_col_s;
      row_r <= nxt_row_s;
    end
  end

  // Line RAM write port; the read in the output block sees the old word.
  always_ff @(posedge clk) begin
    if (rst && in_valid) begin
      line_mem_r[eff_col_s] <= in_data;
    end
  end

  // Output registers: load on an accepted pixel, otherwise hold everything except out_ce.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_ce        <= 1'b0;
      data_line_0   <= 8'd0;
      data_line_1   <= 8'd0;
      out_first_row <= 1'b0;
      out_eol       <= 1'b0;
      out_eof       <= 1'b0;
    end else if (in_valid) begin
      out_ce        <= 1'b1;
      data_line_0   <= in_data;
      data_line_1   <= first_row_s ? 8'd0 : line_mem_r[eff_col_s];
      out_first_row <= first_row_s;
      out_eol       <= last_col_s;
      out_eof       <= last_col_s && last_row_s;
    end else begin
      out_ce        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_u_line_buffer_2row.sv
// ---------------------------------------------------------------------------
// tb_u_line_buffer_2row
// Directed bench for u_line_buffer_2row with a 4x3 image. A table of
// {rst, in_valid, in_sof, in_data, expected outputs} records is built first.
// The table is then applied one record per clock, and the outputs are compared
// 1 time unit after each rising edge. A short hand-written sequence at the end
// covers a mid-row reset.
// ---------------------------------------------------------------------------
module tb_u_line_buffer_2row;

  localparam int W = 4;
  localparam int H = 3;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_sof;
  logic [7:0] in_data;
  logic       out_ce;
  logic [7:0] data_line_0;
  logic [7:0] data_line_1;
  logic       out_first_row;
  logic       out_eol;
  logic       out_eof;

  u_line_buffer_2row #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .COL_W     (2),
    .ROW_W     (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_sof       (in_sof),
    .in_data      (in_data),
    .out_ce       (out_ce),
    .data_line_0  (data_line_0),
    .data_line_1  (data_line_1),
    .out_first_row(out_first_row),
    .out_eol      (out_eol),
    .out_eof      (out_eof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       valid;
    logic       sof;
    logic [7:0] data;
    logic       ce;
    logic [7:0] l0;
    logic [7:0] l1;
    logic       fr;
    logic       eol;
    logic       eof;
  } vec_t;

  vec_t vecs[$];
  vec_t last_v;
  int   n_tests;
  int   n_fail;

  // Append one record and remember it so that idle records can repeat its held outputs.
  task automatic add(input logic r, input logic v, input logic s, input logic [7:0] d,
                     input logic ce, input logic [7:0] l0, input logic [7:0] l1,
                     input logic fr, input logic eol, input logic eof);
    vec_t t;
    t.rst = r; t.valid = v; t.sof = s; t.data = d;
    t.ce = ce; t.l0 = l0; t.l1 = l1; t.fr = fr; t.eol = eol; t.eof = eof;
    vecs.push_back(t);
    last_v = t;
  endtask

  // Idle cycle: out_ce drops, and every other output holds its previous value.
  task automatic add_idle(input logic s);
    add(1'b1, 1'b0, s, 8'hEE, 1'b0, last_v.l0, last_v.l1, last_v.fr, last_v.eol, last_v.eof);
  endtask

  // Full frame of pixels base..base+11 in a previously valid-free row 0, with an optional idle after each pixel.
  task automatic add_frame(input int base, input logic sof_first, input logic gaps);
    for (int i = 0; i < W * H; i++) begin
      logic [7:0] d;
      logic [7:0] up;
      d  = 8'(base + i);
      up = (i < W) ? 8'd0 : 8'(base + i - W);
      add(1'b1, 1'b1, sof_first && (i == 0), d, 1'b1, d, up,
          i < W, (i % W) == (W - 1), i == (W * H - 1));
      if (gaps) add_idle(1'b0);
    end
  endtask

  // Drive one record, clock it, and compare the outputs after the edge.
  task automatic apply(input vec_t t, input int idx);
    logic [27:0] act;
    logic [27:0] exp;
    rst = t.rst; in_valid = t.valid; in_sof = t.sof; in_data = t.data;
    @(posedge clk);
    #1;
    act = {3'd0, out_ce, data_line_0, data_line_1, out_first_row, out_eol, out_eof, 5'd0};
    exp = {3'd0, t.ce, t.l0, t.l1, t.fr, t.eol, t.eof, 5'd0};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec%0d: got ce=%0b l0=%0d l1=%0d fr=%0b eol=%0b eof=%0b, want ce=%0b l0=%0d l1=%0d fr=%0b eol=%0b eof=%0b",
               idx, out_ce, data_line_0, data_line_1, out_first_row, out_eol, out_eof,
               t.ce, t.l0, t.l1, t.fr, t.eol, t.eof);
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = 8'd0;

    // Reset held for 3 cycles with in_valid high: every output stays 0.
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b0, 8'(99 - i), 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    // After release and without in_sof, the first pixel must still be (0,0).
    add_frame(1, 1'b0, 1'b0);
    // A back-to-back frame with in_sof on its first pixel.
    add_frame(21, 1'b1, 1'b0);
    // The same content as the first frame, with in_valid toggling 1,0,1,0.
    add_frame(1, 1'b1, 1'b1);
    // Mid-frame in_sof on the 6th pixel.
    add(1'b1, 1'b1, 1'b1, 8'd41, 1'b1, 8'd41, 8'd0,  1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 8'd42, 1'b1, 8'd42, 8'd0,  1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 8'd43, 1'b1, 8'd43, 8'd0,  1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 8'd44, 1'b1, 8'd44, 8'd0,  1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 8'd45, 1'b1, 8'd45, 8'd41, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 8'd46, 1'b1, 8'd46, 8'd0,  1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 8'd47, 1'b1, 8'd47, 8'd0,  1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 8'd48, 1'b1, 8'd48, 8'd0,  1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 8'd49, 1'b1, 8'd49, 8'd0,  1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 8'd50, 1'b1, 8'd50, 8'd46, 1'b0, 1'b0, 1'b0);
    // in_sof without in_valid is ignored: 51 stays at column 1 of row 1.
    add_idle(1'b1);
    add(1'b1, 1'b1, 1'b0, 8'd51, 1'b1, 8'd51, 8'd47, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset pulsed in row 1: the next pixel is (0,0), and no stale word is shown.
    begin
      vec_t t;
      t = '{rst: 1'b0, valid: 1'b0, sof: 1'b0, data: 8'd0, ce: 1'b0, l0: 8'd0, l1: 8'd0, fr: 1'b0, eol: 1'b0, eof: 1'b0};
      apply(t, 1000);
      t = '{rst: 1'b1, valid: 1'b1, sof: 1'b0, data: 8'd61, ce: 1'b1, l0: 8'd61, l1: 8'd0, fr: 1'b1, eol: 1'b0, eof: 1'b0};
      apply(t, 1001);
      t = '{rst: 1'b1, valid: 1'b1, sof: 1'b0, data: 8'd62, ce: 1'b1, l0: 8'd62, l1: 8'd0, fr: 1'b1, eol: 1'b0, eof: 1'b0};
      apply(t, 1002);
      t = '{rst: 1'b1, valid: 1'b1, sof: 1'b0, data: 8'd63, ce: 1'b1, l0: 8'd63, l1: 8'd0, fr: 1'b1, eol: 1'b0, eof: 1'b0};
      apply(t, 1003);
      t = '{rst: 1'b1, valid: 1'b1, sof: 1'b0, data: 8'd64, ce: 1'b1, l0: 8'd64, l1: 8'd0, fr: 1'b1, eol: 1'b1, eof: 1'b0};
      apply(t, 1004);
      t = '{rst: 1'b1, valid: 1'b1, sof: 1'b0, data: 8'd65, ce: 1'b1, l0: 8'd65, l1: 8'd61, fr: 1'b0, eol: 1'b0, eof: 1'b0};
      apply(t, 1005);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
